// File: rtl/relobi_pkg.sv
// relobi_pkg: shared types for the reliable-OBI N:1 multiplexer.
//   obi_cfg_t           : OBI feature switches (UseRReady, Integrity).
//   relobi_*_t          : request/response channel structs; the handshake
//                         signals req/gnt/rvalid/rready carry 3 TMR copies.
//   idx_width()         : index width for n entries (at least 1 bit).
package relobi_pkg;

  typedef struct packed {
    logic UseRReady;
    logic Integrity;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b1, Integrity: 1'b0};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } relobi_a_chan_t;

  typedef struct packed {
    logic exokay;
  } relobi_r_optional_t;

  typedef struct packed {
    logic [31:0]        rdata;
    logic               err;
    relobi_r_optional_t r_optional;
  } relobi_r_chan_t;

  typedef struct packed {
    relobi_a_chan_t a;
    logic [2:0]     req;
    logic [2:0]     rready;
  } relobi_req_t;

  typedef struct packed {
    relobi_r_chan_t r;
    logic [2:0]     gnt;
    logic [2:0]     rvalid;
  } relobi_rsp_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relobi_tmr_fifo_idx.sv
// relobi_tmr_fifo_idx: triplicated FIFO of source-port indices.
//   Each copy computes its own next pointers/count/storage; the concatenated
//   next state is majority-voted and the voted value is written to all three
//   copies, so a single upset copy is scrubbed on the next edge.
// Ports:
//   clk, rst    clock, async active-high reset (FIFO emptied)
//   push, data  per-copy push strobe and index
//   pop         per-copy pop strobe
//   head        per-copy head entry
//   full, empty per-copy status from the registered count
//   fault       any disagreement between the copies' next state
module relobi_tmr_fifo_idx
  import relobi_pkg::*;
#(
  parameter int Depth = 2,
  parameter int DataW = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             push,
  input  logic [2:0][DataW-1:0]  data,
  input  logic [2:0]             pop,
  output logic [2:0][DataW-1:0]  head,
  output logic [2:0]             full,
  output logic [2:0]             empty,
  output logic                   fault
);

  localparam int PtrW = idx_width(Depth);
  localparam int CntW = PtrW + 1;
  localparam int StW  = Depth*DataW + 2*PtrW + CntW;

  typedef logic [PtrW-1:0]               ptr_t;
  typedef logic [CntW-1:0]               cnt_t;
  typedef logic [Depth-1:0][DataW-1:0]   mem_t;

  mem_t [2:0] mem_q, mem_d;
  ptr_t [2:0] wptr_q, wptr_d, rptr_q, rptr_d;
  cnt_t [2:0] cnt_q, cnt_d;
  logic [2:0] push_ok, pop_ok;

  logic [2:0][StW-1:0] st_d;
  logic [StW-1:0]      st_v;
  mem_t                mem_v;
  ptr_t                wptr_v, rptr_v;
  cnt_t                cnt_v;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(Depth-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      full[k]    = (cnt_q[k] == cnt_t'(Depth));
      empty[k]   = (cnt_q[k] == '0);
      head[k]    = mem_q[k][rptr_q[k]];
      push_ok[k] = push[k] & ~full[k];
      pop_ok[k]  = pop[k] & ~empty[k];

      mem_d[k] = mem_q[k];
      if (push_ok[k]) mem_d[k][wptr_q[k]] = data[k];
      wptr_d[k] = push_ok[k] ? ptr_inc(wptr_q[k]) : wptr_q[k];
      rptr_d[k] = pop_ok[k]  ? ptr_inc(rptr_q[k]) : rptr_q[k];

      cnt_d[k] = cnt_q[k];
      if (push_ok[k] & ~pop_ok[k])      cnt_d[k] = cnt_q[k] + 1'b1;
      else if (pop_ok[k] & ~push_ok[k]) cnt_d[k] = cnt_q[k] - 1'b1;

      st_d[k] = {mem_d[k], wptr_d[k], rptr_d[k], cnt_d[k]};
    end
  end

  assign st_v  = (st_d[0] & st_d[1]) | (st_d[0] & st_d[2]) | (st_d[1] & st_d[2]);
  assign {mem_v, wptr_v, rptr_v, cnt_v} = st_v;
  assign fault = |((st_d[0] ^ st_d[1]) | (st_d[0] ^ st_d[2]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= {3{mem_v}};
      wptr_q <= {3{wptr_v}};
      rptr_q <= {3{rptr_v}};
      cnt_q  <= {3{cnt_v}};
    end
  end

endmodule

// File: rtl/relobi_mux.sv
// relobi_mux: reliable-OBI N:1 multiplexer with TMR handshakes and state.
//   Each TMR copy k arbitrates round-robin on req[k] of all ports, forwards
//   the winner's req[k] (blocked when its FIFO copy is full) and returns gnt[k]
//   to the winner only. The address channel follows the voted winner. Source
//   indices are queued in a TMR FIFO to route in-order responses back.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   sbr_ports_req_i  subordinate-side requests  (req/rready: 3 copies)
//   sbr_ports_rsp_o  subordinate-side responses (gnt/rvalid: 3 copies)
//   mgr_port_req_o   merged request to the manager side
//   mgr_port_rsp_i   merged response from the manager side
//   fault_o          [0] copy disagreement, [1] rvalid with no outstanding txn
module relobi_mux
  import relobi_pkg::*;
#(
  parameter obi_cfg_t ObiCfg       = ObiDefaultConfig,
  parameter type      obi_req_t    = relobi_req_t,
  parameter type      obi_rsp_t    = relobi_rsp_t,
  parameter type      obi_r_chan_t = relobi_r_chan_t,
  parameter int       NumSbrPorts  = 2,
  parameter int       NumMaxTrans  = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t sbr_ports_req_i [NumSbrPorts],
  output obi_rsp_t sbr_ports_rsp_o [NumSbrPorts],
  output obi_req_t mgr_port_req_o,
  input  obi_rsp_t mgr_port_rsp_i,
  output logic [1:0] fault_o
);

  localparam int SelW = idx_width(NumSbrPorts);
  localparam int StW  = 2*SelW + 1;
  typedef logic [SelW-1:0] relobi_mux_sel_t;

  if (ObiCfg.Integrity) begin : g_no_integrity
    $fatal(1, "relobi_mux: Integrity is not supported");
  end
  if (NumSbrPorts < 2) begin : g_bad_ports
    $fatal(1, "relobi_mux: NumSbrPorts must be at least 2");
  end
  if (NumMaxTrans < 1) begin : g_bad_trans
    $fatal(1, "relobi_mux: NumMaxTrans must be at least 1");
  end

  relobi_mux_sel_t [2:0] rr_q, rr_d, lock_idx_q, lock_idx_d, win, head;
  logic [2:0]            lock_q, lock_d, mgr_req, hs, pop, full, empty, rready;
  relobi_mux_sel_t       win_voted, rr_v, lock_idx_v;
  logic                  lock_v, win_mis, st_mis, fifo_fault;
  logic [2:0][StW-1:0]   st_d;
  logic [StW-1:0]        st_v;
  obi_r_chan_t           r_fan;

  // Scan downward so the nearest requester after rr_q is the last to assign.
  always_comb begin
    relobi_mux_sel_t cand;
    for (int k = 0; k < 3; k++) begin
      win[k] = rr_q[k];
      for (int i = NumSbrPorts; i >= 1; i--) begin
        cand = relobi_mux_sel_t'((int'(rr_q[k]) + i) % NumSbrPorts);
        if (sbr_ports_req_i[cand].req[k]) win[k] = cand;
      end
      if (lock_q[k]) win[k] = lock_idx_q[k];
    end
  end

  assign win_voted = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);
  assign win_mis   = |((win[0] ^ win[1]) | (win[0] ^ win[2]));

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      mgr_req[k] = sbr_ports_req_i[win[k]].req[k] & ~full[k];
      hs[k]      = mgr_req[k] & mgr_port_rsp_i.gnt[k];
      rready[k]  = ObiCfg.UseRReady ? sbr_ports_req_i[head[k]].rready[k] : 1'b1;
      pop[k]     = mgr_port_rsp_i.rvalid[k] & rready[k] & ~empty[k];
    end
  end

  always_comb begin
    mgr_port_req_o        = '0;
    mgr_port_req_o.a      = sbr_ports_req_i[win_voted].a;
    mgr_port_req_o.req    = mgr_req;
    mgr_port_req_o.rready = rready;
  end

  assign r_fan = mgr_port_rsp_i.r;

  always_comb begin
    for (int p = 0; p < NumSbrPorts; p++) begin
      sbr_ports_rsp_o[p]   = '0;
      sbr_ports_rsp_o[p].r = r_fan;
      for (int k = 0; k < 3; k++) begin
        sbr_ports_rsp_o[p].gnt[k]    = hs[k] & (win[k] == relobi_mux_sel_t'(p));
        sbr_ports_rsp_o[p].rvalid[k] = mgr_port_rsp_i.rvalid[k] & ~empty[k] &
                                       (head[k] == relobi_mux_sel_t'(p));
      end
    end
  end

  // Lock holds the winner while a forwarded request waits for gnt.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rr_d[k]       = rr_q[k];
      lock_d[k]     = lock_q[k];
      lock_idx_d[k] = lock_idx_q[k];
      if (hs[k]) begin
        rr_d[k]   = win[k];
        lock_d[k] = 1'b0;
      end else if (mgr_req[k]) begin
        lock_d[k]     = 1'b1;
        lock_idx_d[k] = win[k];
      end
      st_d[k] = {rr_d[k], lock_d[k], lock_idx_d[k]};
    end
  end

  assign st_v   = (st_d[0] & st_d[1]) | (st_d[0] & st_d[2]) | (st_d[1] & st_d[2]);
  assign {rr_v, lock_v, lock_idx_v} = st_v;
  assign st_mis = |((st_d[0] ^ st_d[1]) | (st_d[0] ^ st_d[2]));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= {3{relobi_mux_sel_t'(NumSbrPorts-1)}};
      lock_q     <= '0;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= {3{rr_v}};
      lock_q     <= {3{lock_v}};
      lock_idx_q <= {3{lock_idx_v}};
    end
  end

  relobi_tmr_fifo_idx #(
    .Depth (NumMaxTrans),
    .DataW (SelW)
  ) i_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (hs),
    .data  (win),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .fault (fifo_fault)
  );

  assign fault_o = {|(mgr_port_rsp_i.rvalid & empty), win_mis | st_mis | fifo_fault};

endmodule

// File: tb/tb_relobi_mux.sv
// Bench for relobi_mux: directed scenarios plus randomized traffic, all
// checked against a transaction-level model (round-robin pointer, lock flag
// and a queue of outstanding source ports) driven by majority-voted inputs.
module tb_relobi_mux;
  import relobi_pkg::*;

  localparam int NP  = 3;
  localparam int NMT = 2;

  logic        clk = 1'b0;
  logic        rst;
  relobi_req_t sbr_req [NP];
  relobi_rsp_t sbr_rsp [NP];
  relobi_req_t mgr_req;
  relobi_rsp_t mgr_rsp;
  logic [1:0]  fault;

  relobi_mux #(.NumSbrPorts(NP), .NumMaxTrans(NMT)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .sbr_ports_req_i (sbr_req),
    .sbr_ports_rsp_o (sbr_rsp),
    .mgr_port_req_o  (mgr_req),
    .mgr_port_rsp_i  (mgr_rsp),
    .fault_o         (fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int rr;
  bit lk;
  int lk_idx;
  int q[$];

  // observations captured at the sample point of the last step
  logic [2:0]  obs_gnt [NP];
  logic [2:0]  obs_rv  [NP];
  logic [2:0]  obs_mreq;
  logic [31:0] obs_addr;
  logic [1:0]  obs_fault;
  bit          last_hs;
  int          last_win;
  bit          active [NP];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  task automatic idle();
    for (int p = 0; p < NP; p++) begin
      sbr_req[p]        = '0;
      sbr_req[p].rready = 3'b111;
    end
    mgr_rsp = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    rr = NP - 1;
    lk = 1'b0;
    lk_idx = 0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with inputs already driven; samples, checks,
  // advances the model on the posedge and returns at the next negedge.
  task automatic step(input bit do_chk);
    int  win, c;
    bit  full, mreq, hs, pop, rv;
    #1;
    full = (q.size() >= NMT);
    rv   = maj3(mgr_rsp.rvalid);
    win  = -1;
    if (lk) win = lk_idx;
    else begin
      for (int i = 1; i <= NP; i++) begin
        c = (rr + i) % NP;
        if (win < 0 && maj3(sbr_req[c].req)) win = c;
      end
    end
    mreq = (win >= 0) && maj3(sbr_req[win].req) && !full;
    hs   = mreq && maj3(mgr_rsp.gnt);

    for (int p = 0; p < NP; p++) begin
      obs_gnt[p] = sbr_rsp[p].gnt;
      obs_rv[p]  = sbr_rsp[p].rvalid;
    end
    obs_mreq  = mgr_req.req;
    obs_addr  = mgr_req.a.addr;
    obs_fault = fault;

    if (do_chk) begin
      chk("mgr_req", 64'(mgr_req.req), mreq ? 64'h7 : 64'h0);
      if (win >= 0) chk("mgr_addr", 64'(mgr_req.a.addr), 64'(sbr_req[win].a.addr));
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("gnt%0d", p), 64'(sbr_rsp[p].gnt), (hs && p == win) ? 64'h7 : 64'h0);
        chk($sformatf("rvalid%0d", p), 64'(sbr_rsp[p].rvalid),
            (rv && q.size() > 0 && q[0] == p) ? 64'h7 : 64'h0);
        chk($sformatf("r%0d", p), 64'(sbr_rsp[p].r), 64'(mgr_rsp.r));
      end
      if (q.size() > 0) chk("mgr_rready", 64'(mgr_req.rready), 64'(sbr_req[q[0]].rready));
      chk("fault", 64'(fault), {62'd0, rv && q.size() == 0, 1'b0});
    end

    pop = rv && q.size() > 0 && maj3(sbr_req[q[0]].rready);
    last_hs  = hs;
    last_win = win;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (hs) begin
      q.push_back(win);
      rr = win;
      lk = 1'b0;
    end else if (mreq) begin
      lk = 1'b1;
      lk_idx = win;
    end
    @(negedge clk);
  endtask

  initial begin
    do_reset();

    // reset state with idle inputs
    #1;
    chk("rst_mgr_req", 64'(mgr_req.req), 64'h0);
    chk("rst_fault", 64'(fault), 64'h0);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("rst_gnt%0d", p), 64'(sbr_rsp[p].gnt), 64'h0);
      chk($sformatf("rst_rv%0d", p), 64'(sbr_rsp[p].rvalid), 64'h0);
    end
    @(negedge clk);

    // single port
    sbr_req[1].req = 3'b111;
    sbr_req[1].a.addr = 32'h1111_0000;
    mgr_rsp.gnt = 3'b111;
    step(1);
    chk("sp_gnt1", 64'(obs_gnt[1]), 64'h7);
    chk("sp_gnt0", 64'(obs_gnt[0]), 64'h0);
    idle();
    step(1);
    mgr_rsp.rvalid = 3'b111;
    step(1);
    chk("sp_rv1", 64'(obs_rv[1]), 64'h7);
    chk("sp_rv0", 64'(obs_rv[0]), 64'h0);

    // contention: grants alternate starting at port 0
    do_reset();
    sbr_req[0].req = 3'b111; sbr_req[0].a.addr = 32'hA0;
    sbr_req[1].req = 3'b111; sbr_req[1].a.addr = 32'hA1;
    mgr_rsp.gnt = 3'b111;
    for (int i = 0; i < 6; i++) begin
      mgr_rsp.rvalid = (i > 0) ? 3'b111 : 3'b000;
      step(1);
      chk($sformatf("ct_win%0d", i), 64'(obs_gnt[i % 2]), 64'h7);
      chk($sformatf("ct_lose%0d", i), 64'(obs_gnt[(i + 1) % 2]), 64'h0);
    end

    // lock: port 0 held while gnt is low even though rr favours port 1
    do_reset();
    sbr_req[0].req = 3'b111; sbr_req[0].a.addr = 32'hB0;
    mgr_rsp.gnt = 3'b111;
    step(1);
    sbr_req[0].a.addr = 32'hB1;
    mgr_rsp.gnt = 3'b000;
    mgr_rsp.rvalid = 3'b111;
    step(1);
    mgr_rsp.rvalid = 3'b000;
    sbr_req[1].req = 3'b111; sbr_req[1].a.addr = 32'hC1;
    for (int i = 0; i < 2; i++) begin
      step(1);
      chk($sformatf("lk_addr%0d", i), 64'(obs_addr), 64'hB1);
    end
    mgr_rsp.gnt = 3'b111;
    step(1);
    chk("lk_gnt0", 64'(obs_gnt[0]), 64'h7);
    sbr_req[0].req = 3'b000;
    step(1);
    chk("lk_gnt1", 64'(obs_gnt[1]), 64'h7);

    // full: third request blocked until one cycle after a response
    do_reset();
    sbr_req[0].req = 3'b111;
    mgr_rsp.gnt = 3'b111;
    for (int i = 0; i < 2; i++) begin
      sbr_req[0].a.addr = 32'(i);
      step(1);
    end
    sbr_req[0].a.addr = 32'h2;
    step(1);
    chk("full_blk", 64'(obs_mreq), 64'h0);
    chk("full_gnt", 64'(obs_gnt[0]), 64'h0);
    mgr_rsp.rvalid = 3'b111;
    step(1);
    chk("full_popblk", 64'(obs_mreq), 64'h0);
    chk("full_rv", 64'(obs_rv[0]), 64'h7);
    mgr_rsp.rvalid = 3'b000;
    step(1);
    chk("full_fwd", 64'(obs_mreq), 64'h7);

    // fault injection on copy 2 of port 0
    do_reset();
    sbr_req[0].req = 3'b100;
    mgr_rsp.gnt = 3'b111;
    step(0);
    chk("fi_mreq", 64'(obs_mreq), 64'h4);
    chk("fi_fault0", 64'(obs_fault[0]), 64'h1);
    sbr_req[0].req = 3'b000;
    mgr_rsp.gnt = 3'b000;
    mgr_rsp.rvalid = 3'b111;
    step(1);
    chk("fi_rv01", 64'(obs_rv[0] & 3'b011), 64'h0);
    mgr_rsp.rvalid = 3'b000;
    sbr_req[0].req = 3'b111;
    sbr_req[1].req = 3'b111;
    mgr_rsp.gnt = 3'b111;
    step(1);
    chk("fi_rr_kept", 64'(obs_gnt[0]), 64'h7);

    // spurious response
    do_reset();
    mgr_rsp.rvalid = 3'b111;
    step(1);
    chk("sp_fault", 64'(obs_fault), 64'h2);
    for (int p = 0; p < NP; p++) chk($sformatf("sp_rvz%0d", p), 64'(obs_rv[p]), 64'h0);
    mgr_rsp.rvalid = 3'b000;
    step(1);
    chk("sp_fault_clr", 64'(obs_fault), 64'h0);

    // randomized traffic
    do_reset();
    for (int p = 0; p < NP; p++) active[p] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!active[p] && $urandom_range(1) == 1) begin
          active[p] = 1'b1;
          sbr_req[p].a.addr  = $urandom;
          sbr_req[p].a.wdata = $urandom;
          sbr_req[p].a.we    = 1'($urandom_range(1));
          sbr_req[p].a.be    = 4'($urandom_range(15));
        end
        sbr_req[p].req    = active[p] ? 3'b111 : 3'b000;
        sbr_req[p].rready = ($urandom_range(3) != 0) ? 3'b111 : 3'b000;
      end
      mgr_rsp.gnt = ($urandom_range(2) != 0) ? 3'b111 : 3'b000;
      if (q.size() > 0) mgr_rsp.rvalid = ($urandom_range(2) == 0) ? 3'b111 : 3'b000;
      else              mgr_rsp.rvalid = ($urandom_range(15) == 0) ? 3'b111 : 3'b000;
      mgr_rsp.r.rdata = $urandom;
      mgr_rsp.r.err   = 1'($urandom_range(1));
      mgr_rsp.r.r_optional.exokay = 1'($urandom_range(1));
      step(1);
      if (last_hs) active[last_win] = 1'b0;
    end

    // reset with a transaction outstanding discards it
    idle();
    sbr_req[2].req = 3'b111;
    mgr_rsp.gnt = 3'b111;
    step(1);
    do_reset();
    mgr_rsp.rvalid = 3'b111;
    step(1);
    chk("mid_rst_fault", 64'(obs_fault), 64'h2);
    chk("mid_rst_rv2", 64'(obs_rv[2]), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
